// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned CPU_WIDTH  = 64;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] RST_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } ifu_state_t;

  // Pick the 32-bit instruction from a fetched doubleword using PC bit 2.
  function automatic logic [INST_WIDTH-1:0] sel_word(input logic [CPU_WIDTH-1:0] dw,
                                                     input logic              hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory bus and decode handshake of the fetch stage.
interface ifu_fetch_if
  import ifu_fetch_pkg::*;
  ;

  logic                  o_imem_req_valid;
  logic                  i_imem_req_ready;
  logic [CPU_WIDTH-1:0]  o_imem_addr;
  logic                  i_imem_rsp_valid;
  logic [CPU_WIDTH-1:0]  i_imem_rsp_data;
  logic                  i_imem_rsp_err;
  logic                  o_inst_valid;
  logic                  i_inst_ready;
  logic [INST_WIDTH-1:0] o_inst;
  logic [CPU_WIDTH-1:0]  o_inst_pc;
  logic                  o_inst_err;
  logic                  o_inst_misalign;

  modport master (
    output o_imem_req_valid, o_imem_addr,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err,
    output o_inst_valid, o_inst, o_inst_pc, o_inst_err, o_inst_misalign,
    input  i_inst_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_addr,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err,
    input  o_inst_valid, o_inst, o_inst_pc, o_inst_err, o_inst_misalign,
    output i_inst_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage: one outstanding imem request, word select, hold until decode accepts.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic                 i_flush,
  output logic                 o_pc_en,
  ifu_fetch_if.master          fif
);

  ifu_state_t state_q, state_d;
  logic       drop_q, drop_d;
  logic       req_valid;
  logic       ld_rsp, ld_mis, clr_flags;
  logic       misalign;

  logic [CPU_WIDTH-1:0]  fetch_pc_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic [CPU_WIDTH-1:0]  inst_pc_q;
  logic                  inst_err_q;
  logic                  inst_mis_q;

  assign misalign = |i_pc[1:0];

  // Address tracks i_pc directly: the PC only moves on o_pc_en or a flush,
  // so it is stable during a stalled request and follows a redirect.
  assign fif.o_imem_addr      = {i_pc[CPU_WIDTH-1:3], 3'b000};
  assign fif.o_imem_req_valid = req_valid;
  assign fif.o_inst_valid     = (state_q == S_HOLD);
  assign fif.o_inst           = inst_q;
  assign fif.o_inst_pc        = inst_pc_q;
  assign fif.o_inst_err       = inst_err_q;
  assign fif.o_inst_misalign  = inst_mis_q;

  assign o_pc_en = fif.o_inst_valid & fif.i_inst_ready & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    req_valid = 1'b0;
    ld_rsp    = 1'b0;
    ld_mis    = 1'b0;
    clr_flags = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req_valid = ~misalign;
        if (misalign) begin
          if (!i_flush) begin
            state_d = S_HOLD;
            ld_mis  = 1'b1;
          end
        end else if (fif.i_imem_req_ready) begin
          // A request accepted alongside a flush is for the stale PC.
          state_d = S_WAIT;
          drop_d  = i_flush;
        end
      end
      S_WAIT: begin
        if (fif.i_imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || i_flush) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            ld_rsp  = 1'b1;
          end
        end else if (i_flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_flush || fif.i_inst_ready) begin
          state_d   = S_REQ;
          clr_flags = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q <= '0;
      inst_q     <= RST_INST;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
      inst_mis_q <= 1'b0;
    end else begin
      if (state_q == S_REQ) begin
        fetch_pc_q <= i_pc;
      end
      if (ld_mis) begin
        inst_q     <= RST_INST;
        inst_pc_q  <= i_pc;
        inst_err_q <= 1'b0;
        inst_mis_q <= 1'b1;
      end
      if (ld_rsp) begin
        inst_q     <= fif.i_imem_rsp_err ? RST_INST
                                         : sel_word(fif.i_imem_rsp_data, fetch_pc_q[2]);
        inst_pc_q  <= fetch_pc_q;
        inst_err_q <= fif.i_imem_rsp_err;
        inst_mis_q <= 1'b0;
      end
      if (clr_flags) begin
        inst_err_q <= 1'b0;
        inst_mis_q <= 1'b0;
      end
    end
  end

endmodule
